// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the RAM byte loader
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF     = 10;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // Little-endian lane insert: lane k occupies bits [8k+7:8k].
  function automatic logic [WORD_W-1:0] lane_insert(
    input logic [WORD_W-1:0] word,
    input logic [LANE_W-1:0] lane,
    input logic [7:0]        data
  );
    logic [WORD_W-1:0] wide;
    wide = {{(WORD_W-8){1'b0}}, data};
    return word | (wide << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - lane counter and pack register for little-endian word assembly
module byte_packer
  import loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word_next,
  output logic              full
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] word;

  // word_next is the word as it will look once the incoming byte lands
  assign word_next = lane_insert(word, lane, data);
  assign full      = (lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (load) begin
      lane <= lane + LANE_W'(1);
      word <= word_next;
    end
  end

endmodule

// File: rtl/ram_byte_loader.sv
// rtl/ram_byte_loader.sv - byte stream to 32-bit RAM word loader; optional LOADER_CHECKSUM_EN adds checksum port
module ram_byte_loader #(
  parameter int ADDR_W = loader_pkg::ADDR_W_DEF,
  parameter int WORD_W = loader_pkg::WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W+1:0] num_bytes,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_en,
  output logic              busy,
  output logic              done,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              wrap
);

  import loader_pkg::*;

  localparam int CNT_W = ADDR_W + 2;

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic              accept;
  logic              last_byte;
  logic              pk_clear;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word_next;

  assign accept    = (state == COLLECT) && byte_valid;
  assign last_byte = (remaining == CNT_W'(1));
  assign pk_clear  = (state == WRITE) || ((state == IDLE) && start);

  byte_packer u_packer (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (pk_clear),
    .load      (accept),
    .data      (byte_data),
    .word_next (pk_word_next),
    .full      (pk_full)
  );

  // mem_addr doubles as the running address register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      remaining  <= '0;
      byte_ready <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= base_addr;
            remaining <= num_bytes;
            wrap      <= 1'b0;
            busy      <= 1'b1;
            if (num_bytes == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= COLLECT;
              byte_ready <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (pk_full || last_byte) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_en     <= 1'b1;
              mem_data   <= pk_word_next;
            end
          end
        end
        WRITE: begin
          mem_en   <= 1'b0;
          mem_data <= '0;
          mem_addr <= mem_addr + ADDR_W'(1);
          if (&mem_addr) wrap <= 1'b1;
          if (remaining == '0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state      <= COLLECT;
            byte_ready <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      checksum <= '0;
    else if ((state == IDLE) && start)
      checksum <= '0;
    else if (accept)
      checksum <= checksum + byte_data;
  end
`endif

endmodule

// File: tb/tb_ram_byte_loader.sv
// tb/tb_ram_byte_loader.sv - scoreboard bench for ram_byte_loader
module tb_ram_byte_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [11:0] num_bytes = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_en;
  logic        busy;
  logic        done;
  logic        wrap;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  ram_byte_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .num_bytes  (num_bytes),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_en     (mem_en),
    .busy       (busy),
    .done       (done),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .wrap       (wrap)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_wr_cyc = -100;
  int  wr_count = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard
  always @(negedge CLK) begin
    if (!RST && mem_en) begin
      wr_t e;
      wr_count++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_data), 64'(e.data));
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_xfer(input logic [9:0] base, input logic [11:0] n);
    base_addr = base;
    num_bytes = n;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   t;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
    byte_valid = 1'b1;
    byte_data = b;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge CLK);
      acc = byte_ready;
      @(posedge CLK); #1;
      t++;
    end
    if (!acc) chk("byte_accept_timeout", 64'(0), 64'(1));
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (done) found = 1'b1;
    end
    chk(name, 64'(found), 64'(1));
  endtask

  logic [7:0] seq8[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] seq5[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
  int         gaps[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  initial begin
    int w0;
    // reset state
    @(negedge CLK);
    chk("rst_byte_ready", 64'(byte_ready), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_data", 64'(mem_data), 64'(0));
    chk("rst_busy_done_wrap", 64'({busy, done, wrap}), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // two full words back-to-back
    push_wr(10'd0, 32'h04030201);
    push_wr(10'd1, 32'h08070605);
    start_xfer(10'd0, 12'd8);
    for (int i = 0; i < 8; i++) send_byte(seq8[i], 0);
    wait_done("t1_done");
    chk("t1_done_after_write", 64'(cyc - last_wr_cyc), 64'(1));
    chk("t1_wrap", 64'(wrap), 64'(0));
    chk("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    @(negedge CLK);
    chk("t1_done_pulse", 64'({done, busy}), 64'(0));

    // partial final word is zero-padded
    w0 = wr_count;
    push_wr(10'd10, 32'hDDCCBBAA);
    push_wr(10'd11, 32'h000000EE);
    start_xfer(10'd10, 12'd5);
    for (int i = 0; i < 5; i++) send_byte(seq5[i], 0);
    wait_done("t2_done");
    chk("t2_write_count", 64'(wr_count - w0), 64'(2));
    chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    @(posedge CLK); #1;

    // address wrap past 1023
    push_wr(10'd1023, 32'h04030201);
    push_wr(10'd0, 32'h08070605);
    start_xfer(10'd1023, 12'd8);
    for (int i = 0; i < 8; i++) send_byte(seq8[i], 0);
    wait_done("t3_done");
    chk("t3_wrap_set", 64'(wrap), 64'(1));
    chk("t3_queue_empty", 64'(exp_q.size()), 64'(0));
    @(posedge CLK); #1;

    // zero-length transfer; also clears wrap
    w0 = wr_count;
    start_xfer(10'd7, 12'd0);
    @(negedge CLK);
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_busy", 64'(busy), 64'(1));
    chk("t4_wrap_cleared", 64'(wrap), 64'(0));
    @(negedge CLK);
    chk("t4_idle_after", 64'({done, busy}), 64'(0));
    chk("t4_no_write", 64'(wr_count - w0), 64'(0));
    @(posedge CLK); #1;

    // reset mid-transfer
    start_xfer(10'd20, 12'd8);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("t5_rst_outputs", 64'({byte_ready, mem_en, busy, done, wrap}), 64'(0));
    chk("t5_rst_addr", 64'(mem_addr), 64'(0));
    chk("t5_rst_data", 64'(mem_data), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    w0 = wr_count;
    repeat (10) begin @(posedge CLK); #1; end
    chk("t5_no_write_after_rst", 64'(wr_count - w0), 64'(0));
    push_wr(10'd5, 32'h44332211);
    start_xfer(10'd5, 12'd4);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 2);
    wait_done("t5_done");
    chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));
    @(posedge CLK); #1;

    // gaps plus ignored start mid-transfer
    push_wr(10'd0, 32'h04030201);
    push_wr(10'd1, 32'h08070605);
    start_xfer(10'd0, 12'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1;
        base_addr = 10'd100;
        num_bytes = 12'd3;
      end
      if (i == 6) start = 1'b0;
      send_byte(seq8[i], gaps[i]);
    end
    wait_done("t6_done");
`ifdef LOADER_CHECKSUM_EN
    chk("t6_checksum", 64'(checksum), 64'h24);
`endif
    chk("t6_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
